sin_seq_ctrl: RTL

SIN_SEQ_CTRL -- requirements
Module: sin_seq_ctrl

---
 rtl/sin_seq_ctrl_pkg.sv | 32 +++
 rtl/sin_rate_div.sv | 43 ++++
 rtl/sin_seq_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sin_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sin_seq_ctrl_pkg
//
// Shared definitions for the sine-oscillator burst sequencer:
//   - default widths for the coefficient/sample datapath, the burst counter
//     and the sample-rate divider
//   - the sequencer FSM state encoding
//
// No ports; imported by sin_rate_div and sin_seq_ctrl.
// -----------------------------------------------------------------------------
package sin_seq_ctrl_pkg;

    // Signed oscillator coefficient / initial value / sample width.
    // Coefficients are 2cos(w) in Q2.29.
    localparam int DEF_WIDTH = 31;

    // Burst sample-count width.
    localparam int DEF_CNT_W = 16;

    // Sample-rate divider width; sample period is div+1 clk cycles.
    localparam int DEF_DIV_W = 8;

    // Sequencer states. Encodings are fixed so waveforms stay readable.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sin_rate_div.sv
// -----------------------------------------------------------------------------
// sin_rate_div
//
// Sample-rate divider for the burst sequencer. While enabled, the counter runs
// 0,1,..,term,0,1,.. and tick is high in the cycle the count equals term, so
// ticks are term+1 cycles apart. clear forces the count back to 0.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   clear  in   synchronous clear of the count (wins over en)
//   en     in   count enable
//   term   in   terminal value (divider setting)
//   tick   out  combinational, high when enabled and count == term
// -----------------------------------------------------------------------------
module sin_rate_div
    import sin_seq_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] term,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == term);

    // Wrapping on the tick (rather than at the counter's natural overflow)
    // keeps the period exactly term+1 for any term, including 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sin_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sin_seq_ctrl
//
// Burst sequencer for an external sine recurrence oscillator. On an accepted
// start it latches the oscillator coefficient/initial value, burst length and
// sample-rate divider, strobes osc_load once, then steps the oscillator every
// div+1 cycles and captures n_samples samples, finishing with a done pulse.
//
// Timing, counted from the start-accept edge E0:
//   E0            osc_load=1 (LOAD)
//   E1            divider cleared, RUN
//   E(div+2)      first osc_ena (CAPT)
//   E(div+3)      first sample_valid
//   spacing       max(div+1, 2) between osc_ena pulses and between valids;
//                 the CAPT cycle can never itself fire osc_ena, so div=0
//                 gives the minimum period of 2
//   last valid+1  done
// The sample captured is osc_value as presented during the CAPT cycle.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   burst request, sampled only in IDLE
//   abort         in   terminates a burst from any non-IDLE state
//   coef          in   WIDTH signed, 2cos(w) in Q2.29
//   init          in   WIDTH signed, oscillator initial state
//   n_samples     in   CNT_W, burst length (0 => immediate done, no load)
//   div           in   DIV_W, sample period is div+1 cycles
//   osc_load      out  one-cycle oscillator load strobe
//   osc_coef      out  WIDTH signed, latched coef, stable for the burst
//   osc_init      out  WIDTH signed, latched init, stable for the burst
//   osc_ena       out  one-cycle oscillator step enable
//   osc_value     in   WIDTH signed, oscillator output
//   sample_out    out  WIDTH signed, last captured sample (held)
//   sample_valid  out  one-cycle qualifier for sample_out
//   busy          out  high in every state except IDLE
//   done          out  one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module sin_seq_ctrl
    import sin_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [WIDTH-1:0] coef,
    input  logic signed [WIDTH-1:0] init,
    input  logic        [CNT_W-1:0] n_samples,
    input  logic        [DIV_W-1:0] div,
    output logic                    osc_load,
    output logic signed [WIDTH-1:0] osc_coef,
    output logic signed [WIDTH-1:0] osc_init,
    output logic                    osc_ena,
    input  logic signed [WIDTH-1:0] osc_value,
    output logic signed [WIDTH-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [DIV_W-1:0] div_q;

    logic             div_clear;
    logic             div_en;
    logic             div_tick;

    // The divider is cleared on the way into RUN and keeps counting through
    // CAPT so the CAPT cycle is part of the sample period.
    assign div_clear = (state == ST_LOAD);
    assign div_en    = (state == ST_RUN) || (state == ST_CAPT);

    sin_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .en    (div_en),
        .term  (div_q),
        .tick  (div_tick)
    );

    // NOTE: all sequential state is written with non-blocking assignments so
    // every branch below sees the pre-edge values of state, remaining, etc.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and takes priority over abort/start in
        // the same cycle; every register, including the data outputs, is
        // cleared so a reset never leaves a stale sample or coefficient.
        if (rst) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            div_q        <= '0;
            osc_load     <= 1'b0;
            osc_ena      <= 1'b0;
            osc_coef     <= '0;
            osc_init     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            osc_load     <= 1'b0;
            osc_ena      <= 1'b0;
            sample_valid <= 1'b0;
            done         <= 1'b0;

            if (abort && (state != ST_IDLE)) begin
                // A capture pending in CAPT is dropped; sample_out holds.
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (n_samples == '0) begin
                                // Empty burst: report completion without
                                // touching the oscillator.
                                done <= 1'b1;
                            end else begin
                                osc_coef  <= coef;
                                osc_init  <= init;
                                remaining <= n_samples;
                                div_q     <= div;
                                osc_load  <= 1'b1;
                                busy      <= 1'b1;
                                state     <= ST_LOAD;
                            end
                        end
                    end

                    ST_LOAD: begin
                        state <= ST_RUN;
                    end

                    ST_RUN: begin
                        if (div_tick) begin
                            osc_ena <= 1'b1;
                            state   <= ST_CAPT;
                        end
                    end

                    ST_CAPT: begin
                        sample_out   <= osc_value;
                        sample_valid <= 1'b1;
                        remaining    <= remaining - CNT_W'(1);
                        // remaining is never 0 here, so it cannot wrap.
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end

                    ST_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
